// File: rtl/stall_mem_ctrl.sv
// rtl/stall_mem_ctrl.sv - multi-cycle MEM-stage data memory with stall/done handshake
module stall_mem_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              Done,
    output logic              Err
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    op_wr;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_W-1:0]       wdata;
    logic                    post_rst;

    logic [DATA_W-1:0]       mem [WORDS];

    logic                    req_any;
    logic                    req_bad;
    logic                    req_ok;
    logic                    live;
    logic                    accept;
    logic [DEPTH_LOG2-1:0]   addr_idx;
    logic                    unused_addr;

    assign addr_idx    = Addr[DEPTH_LOG2:1];
    assign unused_addr = ^Addr[ADDR_W-1:DEPTH_LOG2+1];

    assign req_any = MemRead | MemWrite;
    assign req_bad = (MemRead & MemWrite) | (ALIGN_CHECK & Addr[0] & req_any);
    assign req_ok  = req_any & ~req_bad;

    // Requests are only looked at in IDLE, and not on the cycle right after reset.
    assign live   = (state == IDLE) & ~Rst & ~post_rst;
    assign accept = live & req_ok;

    assign Stall    = ~Rst & (accept | (state == BUSY));
    assign Err      = live & req_bad;
    assign Done     = ~Rst & (state == DONE);
    assign ReadData = (Done & ~op_wr) ? mem[idx] : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_wr    <= 1'b0;
            idx      <= '0;
            wdata    <= '0;
            post_rst <= 1'b1;
        end else begin
            post_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_wr <= MemWrite;
                        idx   <= addr_idx;
                        wdata <= Data;
                        cnt   <= 4'(LATENCY - 1);
                        state <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    op_wr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; the write lands on the edge that closes DONE.
    always_ff @(posedge Clk) begin
        if (!Rst && state == DONE && op_wr) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_stall_mem_ctrl.sv
// tb/tb_stall_mem_ctrl.sv - scoreboard bench for stall_mem_ctrl
module tb_stall_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data;
    logic        mem_write;
    logic        mem_read;

    logic [15:0] rd0, rd1, rd2;
    logic        st0, st1, st2;
    logic        dn0, dn1, dn2;
    logic        er0, er1, er2;

    int          sel;
    int          lat_exp;
    logic [15:0] o_rdata;
    logic        o_stall, o_done, o_err;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stall_mem_ctrl u_dut (
        .Clk(clk), .Rst(rst), .Addr(addr), .Data(data),
        .MemWrite(mem_write), .MemRead(mem_read),
        .ReadData(rd0), .Stall(st0), .Done(dn0), .Err(er0)
    );

    stall_mem_ctrl #(.LATENCY(1)) u_lat1 (
        .Clk(clk), .Rst(rst), .Addr(addr), .Data(data),
        .MemWrite(mem_write), .MemRead(mem_read),
        .ReadData(rd1), .Stall(st1), .Done(dn1), .Err(er1)
    );

    stall_mem_ctrl #(.LATENCY(15)) u_lat15 (
        .Clk(clk), .Rst(rst), .Addr(addr), .Data(data),
        .MemWrite(mem_write), .MemRead(mem_read),
        .ReadData(rd2), .Stall(st2), .Done(dn2), .Err(er2)
    );

    always_comb begin
        o_rdata = rd0;
        o_stall = st0;
        o_done  = dn0;
        o_err   = er0;
        lat_exp = 4;
        case (sel)
            1: begin o_rdata = rd1; o_stall = st1; o_done = dn1; o_err = er1; lat_exp = 1;  end
            2: begin o_rdata = rd2; o_stall = st2; o_done = dn2; o_err = er2; lat_exp = 15; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(o_stall), 32'd0);
        check({tag, "_done"},  32'(o_done),  32'd0);
        check({tag, "_err"},   32'(o_err),   32'd0);
        check({tag, "_rdata"}, 32'(o_rdata), 32'd0);
    endtask

    // Entered and left at posedge+1; drives one access and follows it to Done.
    task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit hold);
        int          n;
        bit          seen;
        logic [15:0] exp;
        addr      = a;
        data      = d;
        mem_write = wr;
        mem_read  = !wr;
        if (wr) model[a[8:1]] = d;
        else    exp_q.push_back(model[a[8:1]]);
        n    = 0;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                check("done_cycle", 32'(n), 32'(lat_exp));
                check("done_stall", 32'(o_stall), 32'd0);
                if (wr) begin
                    check("wr_rdata", 32'(o_rdata), 32'd0);
                end else if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    check("rd_data", 32'(o_rdata), 32'(exp));
                end
            end else begin
                check("busy_stall", 32'(o_stall), 32'd1);
                check("busy_rdata", 32'(o_rdata), 32'd0);
                check("busy_err",   32'(o_err),   32'd0);
            end
            @(posedge clk); #1;
            n++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        if (!hold) begin
            mem_write = 1'b0;
            mem_read  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        check_quiet("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");
        @(posedge clk); #1;
    endtask

    initial begin
        sel       = 0;
        rst       = 1'b1;
        addr      = '0;
        data      = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Basic write then read
        access(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0);

        // Index wraps modulo the array depth
        access(1'b1, 16'h0202, 16'h1234, 1'b0);
        access(1'b0, 16'h0002, 16'h0000, 1'b0);

        // Conflicting request is rejected and leaves the array alone
        access(1'b1, 16'h0004, 16'h5555, 1'b0);
        addr      = 16'h0004;
        data      = 16'h9999;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("both_err",   32'(o_err),   32'd1);
            check("both_stall", 32'(o_stall), 32'd0);
            check("both_done",  32'(o_done),  32'd0);
            check("both_rdata", 32'(o_rdata), 32'd0);
            @(posedge clk); #1;
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        @(posedge clk); #1;
        access(1'b0, 16'h0004, 16'h0000, 1'b0);

        // Odd address is misaligned
        addr     = 16'h0005;
        mem_read = 1'b1;
        @(negedge clk);
        check("odd_err",   32'(o_err),   32'd1);
        check("odd_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        check("odd_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a write aborts it
        access(1'b1, 16'h0020, 16'h7777, 1'b0);
        addr      = 16'h0020;
        data      = 16'hAAAA;
        mem_write = 1'b1;
        @(negedge clk);
        check("mid_stall0", 32'(o_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_stall1", 32'(o_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("mid_after");
        @(posedge clk); #1;
        mem_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_nodone", 32'(o_done), 32'd0);
            @(posedge clk); #1;
        end
        access(1'b0, 16'h0020, 16'h0000, 1'b0);

        // Held read is not re-accepted; write accepted right after Done
        access(1'b0, 16'h0010, 16'h0000, 1'b1);
        access(1'b1, 16'h0010, 16'hCAFE, 1'b0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0);

        // Latency extremes
        do_reset();
        sel = 1;
        access(1'b1, 16'h0040, 16'h0F0F, 1'b0);
        access(1'b0, 16'h0040, 16'h0000, 1'b0);
        do_reset();
        sel = 2;
        access(1'b1, 16'h0042, 16'hA5A5, 1'b0);
        access(1'b0, 16'h0042, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
